// File: rtl/multicycle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_pkg
// Purpose  : Shared types and constants for the multi-cycle MIPS core.
// Revision : 1.0 - initial release
// ============================================================================
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    ADDIEX = 4'd8,
    ADDIWB = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11,
    HALT   = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_B     = 2'd0,
    SRCB_FOUR  = 2'd1,
    SRCB_IMM   = 2'd2,
    SRCB_BRIMM = 2'd3
  } srcb_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2
  } pcsrc_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  function automatic logic [31:0] signext(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Controller FSM; turns state/opcode/funct/mem_ready into selects.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control
  import multicycle_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output state_t     state,
  output logic       ir_we,
  output logic       pc_we,
  output logic       branch,
  output pcsrc_t     pc_src,
  output logic       ab_we,
  output logic       aluout_we,
  output logic       mdr_we,
  output logic       alu_srca_reg,
  output srcb_t      alu_srcb,
  output alu_op_t    alu_op,
  output logic       rf_we,
  output logic       rf_dst_rd,
  output logic       rf_from_mem,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord
);

  state_t  r_state;
  state_t  w_next;
  alu_op_t w_funct_op;
  logic    w_funct_ok;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  assign state = r_state;

  always_comb begin
    w_funct_op = ALU_ADD;
    w_funct_ok = 1'b1;
    case (funct)
      FN_ADD:  w_funct_op = ALU_ADD;
      FN_SUB:  w_funct_op = ALU_SUB;
      FN_AND:  w_funct_op = ALU_AND;
      FN_OR:   w_funct_op = ALU_OR;
      FN_SLT:  w_funct_op = ALU_SLT;
      default: w_funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:  if (mem_ready) w_next = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE:     w_next = EXEC;
          OP_ADDI:      w_next = ADDIEX;
          OP_BEQ:       w_next = BRANCH;
          OP_J:         w_next = JUMP;
          default:      w_next = HALT;
        endcase
      end
      MEMADR: w_next = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (mem_ready) w_next = MEMWB;
      MEMWR:  if (mem_ready) w_next = FETCH;
      EXEC:   w_next = w_funct_ok ? ALUWB : HALT;
      ADDIEX: w_next = ADDIWB;
      MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: w_next = FETCH;
      default: w_next = HALT;
    endcase
  end

  // Every state shares the one ALU; srca/srcb pick PC or A against 4/imm/B.
  always_comb begin
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    branch       = 1'b0;
    pc_src       = PCSRC_ALU;
    ab_we        = 1'b0;
    aluout_we    = 1'b0;
    mdr_we       = 1'b0;
    alu_srca_reg = 1'b0;
    alu_srcb     = SRCB_B;
    alu_op       = ALU_ADD;
    rf_we        = 1'b0;
    rf_dst_rd    = 1'b0;
    rf_from_mem  = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    iord         = 1'b0;
    case (r_state)
      FETCH: begin
        mem_req  = 1'b1;
        alu_srcb = SRCB_FOUR;
        ir_we    = mem_ready;
        pc_we    = mem_ready;
      end
      DECODE: begin
        ab_we     = 1'b1;
        alu_srcb  = SRCB_BRIMM;
        aluout_we = 1'b1;
      end
      MEMADR, ADDIEX: begin
        alu_srca_reg = 1'b1;
        alu_srcb     = SRCB_IMM;
        aluout_we    = 1'b1;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mdr_we  = mem_ready;
      end
      MEMWB: begin
        rf_we       = 1'b1;
        rf_from_mem = 1'b1;
      end
      MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      EXEC: begin
        alu_srca_reg = 1'b1;
        alu_op       = w_funct_op;
        aluout_we    = 1'b1;
      end
      ALUWB: begin
        rf_we     = 1'b1;
        rf_dst_rd = 1'b1;
      end
      ADDIWB: rf_we = 1'b1;
      BRANCH: begin
        alu_srca_reg = 1'b1;
        alu_op       = ALU_SUB;
        branch       = 1'b1;
        pc_src       = PCSRC_ALUOUT;
      end
      JUMP: begin
        pc_we  = 1'b1;
        pc_src = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_datapath.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_datapath
// Purpose  : Multi-cycle MIPS subset core with unified req/ready memory port.
// Options  : MULTICYCLE_PERF_CNT_EN adds cycle_count / instr_count outputs.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_datapath
  import multicycle_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32,
  parameter int          ADDR_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc_q,
  output logic [31:0]       instr,
  output logic              reg_write,
  output logic              halted
`ifdef MULTICYCLE_PERF_CNT_EN
  ,
  output logic [31:0]       cycle_count,
  output logic [31:0]       instr_count
`endif
);

  localparam int c_ridx_w = $clog2(NUM_REGS);

  logic [31:0] r_pc, r_ir, r_a, r_b, r_aluout, r_mdr;
  logic [31:0] r_regs [NUM_REGS];

  state_t  w_state;
  pcsrc_t  w_pc_src;
  srcb_t   w_srcb;
  alu_op_t w_alu_op;
  logic    w_ir_we, w_pc_we, w_branch, w_ab_we, w_aluout_we, w_mdr_we;
  logic    w_srca_reg, w_rf_we, w_rf_dst_rd, w_rf_from_mem;
  logic    w_mem_req, w_mem_we, w_iord;

  logic [c_ridx_w-1:0] w_rs, w_rt, w_rd, w_rf_waddr;
  logic [31:0] w_imm_ext, w_rs_val, w_rt_val, w_rf_wdata;
  logic [31:0] w_alu_a, w_alu_b, w_alu_y, w_pc_next;
  logic        w_alu_zero, w_pc_load;

  multicycle_control u_control (
    .clock        (clock),
    .reset        (reset),
    .opcode       (r_ir[31:26]),
    .funct        (r_ir[5:0]),
    .mem_ready    (mem_ready),
    .state        (w_state),
    .ir_we        (w_ir_we),
    .pc_we        (w_pc_we),
    .branch       (w_branch),
    .pc_src       (w_pc_src),
    .ab_we        (w_ab_we),
    .aluout_we    (w_aluout_we),
    .mdr_we       (w_mdr_we),
    .alu_srca_reg (w_srca_reg),
    .alu_srcb     (w_srcb),
    .alu_op       (w_alu_op),
    .rf_we        (w_rf_we),
    .rf_dst_rd    (w_rf_dst_rd),
    .rf_from_mem  (w_rf_from_mem),
    .mem_req      (w_mem_req),
    .mem_we       (w_mem_we),
    .iord         (w_iord)
  );

  assign w_rs       = r_ir[21 +: c_ridx_w];
  assign w_rt       = r_ir[16 +: c_ridx_w];
  assign w_rd       = r_ir[11 +: c_ridx_w];
  assign w_imm_ext  = signext(r_ir[15:0]);
  assign w_rs_val   = (w_rs == '0) ? 32'd0 : r_regs[w_rs];
  assign w_rt_val   = (w_rt == '0) ? 32'd0 : r_regs[w_rt];
  assign w_rf_waddr = w_rf_dst_rd ? w_rd : w_rt;
  assign w_rf_wdata = w_rf_from_mem ? r_mdr : r_aluout;

  assign w_alu_a = w_srca_reg ? r_a : r_pc;

  always_comb begin
    w_alu_b = r_b;
    case (w_srcb)
      SRCB_FOUR:  w_alu_b = 32'd4;
      SRCB_IMM:   w_alu_b = w_imm_ext;
      SRCB_BRIMM: w_alu_b = {w_imm_ext[29:0], 2'b00};
      default:    w_alu_b = r_b;
    endcase
  end

  always_comb begin
    w_alu_y = 32'd0;
    case (w_alu_op)
      ALU_ADD: w_alu_y = w_alu_a + w_alu_b;
      ALU_SUB: w_alu_y = w_alu_a - w_alu_b;
      ALU_AND: w_alu_y = w_alu_a & w_alu_b;
      ALU_OR:  w_alu_y = w_alu_a | w_alu_b;
      ALU_SLT: w_alu_y = {31'd0, $signed(w_alu_a) < $signed(w_alu_b)};
      default: w_alu_y = 32'd0;
    endcase
  end

  assign w_alu_zero = (w_alu_y == 32'd0);
  assign w_pc_load  = w_pc_we | (w_branch & w_alu_zero);

  always_comb begin
    w_pc_next = w_alu_y;
    case (w_pc_src)
      PCSRC_ALUOUT: w_pc_next = r_aluout;
      PCSRC_JUMP:   w_pc_next = {r_pc[31:28], r_ir[25:0], 2'b00};
      default:      w_pc_next = w_alu_y;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_ir     <= 32'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_aluout <= 32'd0;
      r_mdr    <= 32'd0;
    end else begin
      if (w_pc_load)   r_pc     <= w_pc_next;
      if (w_ir_we)     r_ir     <= mem_rdata;
      if (w_aluout_we) r_aluout <= w_alu_y;
      if (w_mdr_we)    r_mdr    <= mem_rdata;
      if (w_ab_we) begin
        r_a <= w_rs_val;
        r_b <= w_rt_val;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 32'd0;
    end else if (w_rf_we && (w_rf_waddr != '0)) begin
      r_regs[w_rf_waddr] <= w_rf_wdata;
    end
  end

  // The state register clears to FETCH, which requests; gate with reset so the
  // request drops the instant reset is applied and stays low while it is held.
  assign mem_req   = w_mem_req & ~reset;
  assign mem_we    = w_mem_we & ~reset;
  assign mem_addr  = w_iord ? r_aluout[ADDR_W-1:0] : r_pc[ADDR_W-1:0];
  assign mem_wdata = r_b;
  assign pc_q      = r_pc;
  assign instr     = r_ir;
  assign reg_write = w_rf_we;
  assign halted    = (w_state == HALT);

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] r_cycle_count, r_instr_count;
  logic        w_instr_done;

  assign w_instr_done = (w_state == MEMWB) || (w_state == ALUWB) ||
                        (w_state == ADDIWB) || (w_state == BRANCH) ||
                        (w_state == JUMP) || ((w_state == MEMWR) && mem_ready);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cycle_count <= 32'd0;
      r_instr_count <= 32'd0;
    end else begin
      if (w_state != HALT) r_cycle_count <= r_cycle_count + 32'd1;
      if (w_instr_done)    r_instr_count <= r_instr_count + 32'd1;
    end
  end

  assign cycle_count = r_cycle_count;
  assign instr_count = r_instr_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_datapath
// Purpose  : Directed vector table plus handshake/halt/reset sequences.
// Options  : MULTICYCLE_PERF_CNT_EN also checks the performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ready, reg_write, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_q, instr;
`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] cycle_count, instr_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_datapath dut (
    .clock     (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc_q      (pc_q),
    .instr     (instr),
    .reg_write (reg_write),
    .halted    (halted)
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    .cycle_count (cycle_count),
    .instr_count (instr_count)
`endif
  );

  // Memory keyed by the low address byte, one word per address, so that an
  // unaligned store (addr 5) cannot clobber neighbouring instruction words.
  logic [31:0] mem [256];
  int          lat = 0;
  int          wcnt = 0;
  logic        clr = 1'b0, ld = 1'b0;
  logic [7:0]  ld_addr = 8'd0;
  logic [31:0] ld_data = 32'd0;
  int          wr_cnt = 0;
  logic [31:0] wr_addr = 32'd0, wr_data = 32'd0;
  int          rw_cnt = 0;
  int          stab_err = 0;
  logic        pend = 1'b0, p_we = 1'b0;
  logic [31:0] p_addr = 32'd0, p_wdata = 32'd0;

  assign mem_ready = mem_req && (wcnt >= lat);
  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      wr_cnt <= 0;
    end else if (ld) begin
      mem[ld_addr] <= ld_data;
    end else if (mem_req && mem_we && mem_ready) begin
      mem[mem_addr[7:0]] <= mem_wdata;
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= mem_addr;
      wr_data <= mem_wdata;
    end
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else                       wcnt <= 0;
  end

  always @(posedge clk) begin
    if (clr)            rw_cnt <= 0;
    else if (reg_write) rw_cnt <= rw_cnt + 1;
  end

  // A stalled request must present identical addr/we/wdata on the next cycle.
  always @(negedge clk) begin
    if (reset) begin
      pend <= 1'b0;
    end else begin
      if (pend && mem_req && (mem_addr != p_addr || mem_we != p_we || mem_wdata != p_wdata))
        stab_err <= stab_err + 1;
      pend    <= mem_req && !mem_ready;
      p_addr  <= mem_addr;
      p_we    <= mem_we;
      p_wdata <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic start(input int latency);
    reset = 1'b1;
    lat   = latency;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    ld      = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] i0, i1, i2;
    logic [7:0]  daddr;
    logic [31:0] dval;
    int          cycles;
    int          rchk;
    logic [31:0] rexp;
    logic [31:0] pcexp;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   req_seen;
    logic found;

    vecs[0]  = '{32'h20010005, 32'h0, 32'h0, 8'h80, 32'h0, 4, 1, 32'h00000005, 32'h4};
    vecs[1]  = '{32'h2001FFFF, 32'h0, 32'h0, 8'h80, 32'h0, 4, 1, 32'hFFFFFFFF, 32'h4};
    vecs[2]  = '{32'h2001FFFF, 32'h20020003, 32'h00411822, 8'h80, 32'h0, 12, 3, 32'h00000004, 32'hC};
    vecs[3]  = '{32'h2001FFFF, 32'h20020003, 32'h00211820, 8'h80, 32'h0, 12, 3, 32'hFFFFFFFE, 32'hC};
    vecs[4]  = '{32'h20010F0F, 32'h200200FF, 32'h00221824, 8'h80, 32'h0, 12, 3, 32'h0000000F, 32'hC};
    vecs[5]  = '{32'h20010F0F, 32'h200200FF, 32'h00221825, 8'h80, 32'h0, 12, 3, 32'h00000FFF, 32'hC};
    vecs[6]  = '{32'h2001FFFF, 32'h20020001, 32'h0022182A, 8'h80, 32'h0, 12, 3, 32'h00000001, 32'hC};
    vecs[7]  = '{32'h08000004, 32'h0, 32'h0, 8'h80, 32'h0, 3, 0, 32'h0, 32'h10};
    vecs[8]  = '{32'h20010001, 32'h10200004, 32'h0, 8'h80, 32'h0, 7, 1, 32'h1, 32'h8};
    vecs[9]  = '{32'h10000002, 32'h0, 32'h0, 8'h80, 32'h0, 3, 0, 32'h0, 32'hC};
    vecs[10] = '{32'h20000005, 32'h20010003, 32'h0, 8'h80, 32'h0, 8, 1, 32'h3, 32'h8};
    vecs[11] = '{32'h8C020008, 32'h0, 32'h0, 8'h08, 32'hCAFEF00D, 5, 2, 32'hCAFEF00D, 32'h4};
    vecs[12] = '{32'h20010020, 32'h8C22FFFC, 32'h0, 8'h1C, 32'h12345678, 9, 2, 32'h12345678, 32'h8};

    // Reset state
    start(0);
    chk("rst_pc", pc_q, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_regwrite", {31'd0, reg_write}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);

    // Table-driven single-program vectors, zero-wait memory
    for (int i = 0; i < 13; i++) begin
      start(0);
      load(8'h00, vecs[i].i0);
      load(8'h04, vecs[i].i1);
      load(8'h08, vecs[i].i2);
      load(vecs[i].daddr, vecs[i].dval);
      reset = 1'b0;
      run(vecs[i].cycles);
      chk($sformatf("vec%0d_reg", i), dut.r_regs[vecs[i].rchk], vecs[i].rexp);
      chk($sformatf("vec%0d_pc", i), pc_q, vecs[i].pcexp);
    end

    // addi CPI 4, single reg_write pulse
    start(0);
    load(8'h00, 32'h20010005);
    reset = 1'b0;
    run(3);
    chk("t1_regwrite_hi", {31'd0, reg_write}, 32'd1);
    chk("t1_r1_before", dut.r_regs[1], 32'd0);
    run(1);
    chk("t1_r1", dut.r_regs[1], 32'd5);
    chk("t1_pc", pc_q, 32'h4);
    chk("t1_rw_cnt", rw_cnt, 1);
`ifdef MULTICYCLE_PERF_CNT_EN
    chk("t1_cycles", cycle_count, 32'd4);
    chk("t1_instrs", instr_count, 32'd1);
`endif

    // lw with 3 wait cycles per access: 11 cycles total
    start(3);
    load(8'h00, 32'h8C020008);
    load(8'h08, 32'hDEADBEEF);
    reset = 1'b0;
    run(6);
    chk("t2_memrd_req", {31'd0, mem_req}, 32'd1);
    chk("t2_memrd_addr", mem_addr, 32'h8);
    chk("t2_memrd_we", {31'd0, mem_we}, 32'd0);
    run(4);
    chk("t2_r2_before", dut.r_regs[2], 32'h0);
    chk("t2_wb_regwrite", {31'd0, reg_write}, 32'd1);
    run(1);
    chk("t2_r2", dut.r_regs[2], 32'hDEADBEEF);
    chk("t2_pc", pc_q, 32'h4);

    // sw to unaligned addr 5, then signed slt
    start(0);
    load(8'h00, 32'h20010005);
    load(8'h04, 32'h20020007);
    load(8'h08, 32'hAC220000);
    load(8'h0C, 32'h0022182A);
    reset = 1'b0;
    run(16);
    chk("t3_wr_cnt", wr_cnt, 1);
    chk("t3_wr_addr", wr_addr, 32'h5);
    chk("t3_wr_data", wr_data, 32'h7);
    chk("t3_mem5", mem[5], 32'h7);
    chk("t3_r3", dut.r_regs[3], 32'h1);
    chk("t3_rw_cnt", rw_cnt, 3);

    // j to 0x10 then beq $0,$0,-1 loop every 3 cycles
    start(0);
    load(8'h00, 32'h08000004);
    load(8'h10, 32'h1000FFFF);
    reset = 1'b0;
    run(3);
    chk("t4_pc_entry", pc_q, 32'h10);
    for (int k = 0; k < 3; k++) begin
      run(1);
      chk($sformatf("t4_pc_mid%0d", k), pc_q, 32'h14);
      run(2);
      chk($sformatf("t4_pc_loop%0d", k), pc_q, 32'h10);
`ifdef MULTICYCLE_PERF_CNT_EN
      chk($sformatf("t4_instrs%0d", k), instr_count, 32'(2 + k));
      chk($sformatf("t4_cycles%0d", k), cycle_count, 32'(6 + 3 * k));
`endif
    end

    // Illegal opcode halts after DECODE; no further requests or writes
    start(0);
    load(8'h00, 32'h20010005);
    load(8'h04, 32'hFC000000);
    reset = 1'b0;
    run(5);
    chk("t5_not_halted", {31'd0, halted}, 32'd0);
    run(1);
    chk("t5_halted", {31'd0, halted}, 32'd1);
    req_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_req) req_seen++;
    end
    chk("t5_no_req", req_seen, 0);
    chk("t5_still_halted", {31'd0, halted}, 32'd1);
    chk("t5_r1", dut.r_regs[1], 32'd5);
    chk("t5_rw_cnt", rw_cnt, 1);
    chk("t5_pc", pc_q, 32'h8);
`ifdef MULTICYCLE_PERF_CNT_EN
    chk("t5_cycles", cycle_count, 32'd6);
    chk("t5_instrs", instr_count, 32'd1);
`endif

    // Reset during a stalled store
    start(3);
    load(8'h00, 32'h20010005);
    load(8'h04, 32'h20020007);
    load(8'h08, 32'hAC220000);
    reset = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (mem_req && mem_we) found = 1'b1;
    end
    chk("t6_reached_memwr", {31'd0, found}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_req_drop", {31'd0, mem_req}, 32'd0);
    chk("t6_we_drop", {31'd0, mem_we}, 32'd0);
    run(2);
    chk("t6_no_write", wr_cnt, 0);
    chk("t6_mem5", mem[5], 32'h0);
    reset = 1'b0;
    #1;
    chk("t6_fetch_req", {31'd0, mem_req}, 32'd1);
    chk("t6_fetch_we", {31'd0, mem_we}, 32'd0);
    chk("t6_fetch_addr", mem_addr, 32'h0);
    chk("t6_r1_cleared", dut.r_regs[1], 32'h0);

    chk("stall_stability", stab_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Parametrised multi-cycle successor to the single-cycle MIPS datapath.
- Executes lw, sw, add, sub, and, or, slt, addi, beq and j, one instruction per 3–5 cycles.
- One shared ALU, an internal register file and an FSM controller.
- Talks to a single unified instruction/data memory through a req/ready handshake, so memory may stall the core.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NUM_REGS, 32, register-file depth (power of 2, 8..32); register index width is log2(NUM_REGS), taken from the low bits of each 5-bit field.
- ADDR_W, 32, width of mem_addr; the PC is held at 32 bits and truncated to ADDR_W.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe, valid only with mem_req.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  32  store data (rt value).
- mem_rdata  in  32  read data, valid when mem_ready=1.
- mem_ready  in  1  access completes this cycle.
- pc_q  out  32  current PC.
- instr  out  32  instruction register.
- reg_write  out  1  register-file write this cycle.
- halted  out  1  core is in HALT.

Behaviour:
- Reset values:
  - pc_q=RESET_PC; instr=0; all registers=0; state=FETCH.
  - mem_req=mem_we=reg_write=halted=0; mem_addr=RESET_PC; mem_wdata=0.
  - Outputs are glitch-free registered or decoded from state only.
- Register 0 always reads 0; writes to it are discarded.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=PC.
  - Stay while mem_ready=0.
  - On ready: instr<=mem_rdata, PC<=PC+4, go to DECODE.
- DECODE:
  - Latch A=R[rs], B=R[rt].
  - ALUOut<=PC+ (signext(imm)<<2), the branch target.
  - Next state by opcode:
    - 0x23/0x2B -> MEMADR
    - 0x00 -> EXEC
    - 0x08 -> ADDIEX
    - 0x04 -> BRANCH
    - 0x02 -> JUMP
    - any other -> HALT
- MEMADR: ALUOut<=A+signext(imm); lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_req=1, addr=ALUOut; hold until ready; capture MDR, then MEMWB.
- MEMWB: R[rt]<=MDR, reg_write=1, then FETCH.
- MEMWR: mem_req=1, mem_we=1, addr=ALUOut, wdata=B; hold until ready, then FETCH.
- EXEC:
  - ALUOut<=A op B, with funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed).
  - Other funct -> HALT without writeback.
  - Otherwise go to ALUWB.
- ALUWB: R[rd]<=ALUOut, reg_write=1, then FETCH.
- ADDIEX: ALUOut<=A+signext(imm), then ADDIWB.
- ADDIWB: R[rt]<=ALUOut, reg_write=1, then FETCH.
- BRANCH: if A==B, PC<=ALUOut; then FETCH.
- JUMP: PC<={PC[31:28], instr[25:0], 2'b00}, then FETCH.
- HALT: absorbing; halted=1, no memory requests; exits only on reset.
- Arithmetic: all 32-bit, wrap-around, no overflow trap.
- Handshake:
  - mem_addr, mem_we and mem_wdata are stable for every cycle mem_req is high.
  - mem_ready is ignored when mem_req=0.
  - Zero-wait memory (ready tied 1) gives CPI: lw 5, sw 4, R/addi 4, beq 3, j 3.
- Reset asserted mid-access: mem_req drops asynchronously, nothing is written; after release the core resumes at FETCH of RESET_PC.

Optional Feature:
- Macro MULTICYCLE_PERF_CNT_EN.
- When defined:
  - Adds outputs cycle_count[31:0] and instr_count[31:0], both reset to 0.
  - cycle_count increments every non-HALT cycle.
  - instr_count increments on each transition into FETCH from a completing state (MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP).
  - Both wrap at 2^32.
- When undefined: the ports are absent and there is no counter logic.

Decomposition:
- Package multicycle_pkg holds:
  - state_t enum (FETCH..HALT);
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J);
  - funct constants;
  - alu_op_t (ADD, SUB, AND, OR, SLT).
- One sub-module, multicycle_control: the FSM, producing mux selects and enables from state, opcode, funct and mem_ready.
- Datapath registers and the ALU live in the top level; the existing ALU module may be reused if it matches alu_op_t.

Test Plan:
1. Reset, ready=1, mem word0=addi $1,$0,5 (0x20010005) -> after 4 cycles R1=5, reg_write pulsed once, pc_q=4.
2. lw $2,8($0) with mem[8]=0xDEADBEEF and ready delayed 3 cycles on every access -> mem_req held with stable addr 8, R2=0xDEADBEEF, total 11 cycles.
3. R1=5 and R2=7, then sw $2,0($1) then slt $3,$1,$2 -> write at addr 5 with wdata 7 and we=1 for exactly one accepted cycle; R3=1.
4. beq $0,$0,-1 at PC 0x10 -> pc_q returns to 0x10 every 3 cycles; with the macro, instr_count increments once per loop.
5. Opcode 0x3F fetched -> halted=1 after DECODE, mem_req stays 0 for 20 cycles, registers unchanged.
6. Reset asserted during a MEMWR stall -> mem_req low immediately, memory not written, next request after release is FETCH at RESET_PC.
